// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/ack bus between fetch unit and memory
interface if_fetch_unit_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end: PC, memory req/ack, redirect and skid handling
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STALL_W  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                flush_i,
    input  logic [31:0]         new_pc_i,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_i,
    if_fetch_unit_if.master     imem,
    output logic [31:0]         if_pc_o,
    output logic [31:0]         if_inst_o,
    output logic                if_valid_o,
    output logic                stallreq_from_if_o
);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redirect_pc, redirect_pc_nxt;
    logic        redirect_pending, redirect_pending_nxt;
    logic        req_nxt;
    logic [31:0] addr_nxt;
    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        capture;
    logic        skid_valid;
    logic [31:0] skid_pc, skid_inst;
    logic        unused_stall;

    assign unused_stall       = ^stall_i[STALL_W-1:2];
    assign redirect           = flush_i | branch_flag_i;
    assign redirect_tgt       = flush_i ? new_pc_i : branch_target_i;
    assign stallreq_from_if_o = (state == REQ) && !imem.inst_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            redirect_pc      <= '0;
            redirect_pending <= 1'b0;
            imem.inst_req_o  <= 1'b0;
            imem.inst_addr_o <= RESET_PC;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            redirect_pc      <= redirect_pc_nxt;
            redirect_pending <= redirect_pending_nxt;
            imem.inst_req_o  <= req_nxt;
            imem.inst_addr_o <= addr_nxt;
        end
    end

    // A redirect seen in IDLE defers the request one cycle so it always leaves from redirect_pc.
    always_comb begin
        state_nxt            = state;
        pc_nxt               = pc;
        redirect_pc_nxt      = redirect_pc;
        redirect_pending_nxt = redirect_pending;
        req_nxt              = imem.inst_req_o;
        addr_nxt             = imem.inst_addr_o;
        capture              = 1'b0;
        case (state)
            IDLE: begin
                if (!stall_i[0] && !skid_valid && !redirect) begin
                    state_nxt            = REQ;
                    req_nxt              = 1'b1;
                    addr_nxt             = redirect_pending ? redirect_pc : pc;
                    redirect_pending_nxt = 1'b0;
                end
            end
            REQ: begin
                if (imem.inst_ack_i) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    if (!redirect) begin
                        capture = 1'b1;
                        pc_nxt  = imem.inst_addr_o + 32'd4;
                    end
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (imem.inst_ack_i) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            redirect_pc_nxt      = redirect_tgt;
            redirect_pending_nxt = 1'b1;
        end
    end

    // Skid entry is only ever filled from an empty buffer: requests stop while it is occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc_o    <= '0;
            if_inst_o  <= '0;
            if_valid_o <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= '0;
        end else if (redirect) begin
            if_valid_o <= 1'b0;
            skid_valid <= 1'b0;
        end else if (capture) begin
            if (stall_i[1]) begin
                skid_valid <= 1'b1;
                skid_pc    <= imem.inst_addr_o;
                skid_inst  <= imem.inst_rdata_i;
            end else begin
                if_pc_o    <= imem.inst_addr_o;
                if_inst_o  <= imem.inst_rdata_i;
                if_valid_o <= 1'b1;
            end
        end else if (!stall_i[1]) begin
            if (skid_valid) begin
                if_pc_o    <= skid_pc;
                if_inst_o  <= skid_inst;
                if_valid_o <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  stall;
    logic        flush, branch;
    logic [31:0] new_pc, br_tgt;
    logic [31:0] if_pc, if_inst, w_pc, w_inst;
    logic        if_valid, stallreq, w_valid, w_stallreq;
    logic [31:0] slow_addr;
    logic        stray_ack;
    logic        seen_33;
    int          total = 0;
    int          bad = 0;

    if_fetch_unit_if bus();
    if_fetch_unit_if bus_w();

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(new_pc),
        .branch_flag_i(branch), .branch_target_i(br_tgt), .imem(bus),
        .if_pc_o(if_pc), .if_inst_o(if_inst), .if_valid_o(if_valid),
        .stallreq_from_if_o(stallreq)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .STALL_W(7)) dut_w (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .new_pc_i(new_pc),
        .branch_flag_i(branch), .branch_target_i(br_tgt), .imem(bus_w),
        .if_pc_o(w_pc), .if_inst_o(w_inst), .if_valid_o(w_valid),
        .stallreq_from_if_o(w_stallreq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'h10:  return 32'h44;
            default: return a ^ 32'h5A00_0000;
        endcase
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // memory: answers the main DUT after 0 or 3 wait cycles, or injects a stray ack
    initial begin
        int wc;
        wc = 0;
        bus.inst_ack_i   = 1'b0;
        bus.inst_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            bus.inst_ack_i = 1'b0;
            if (stray_ack) begin
                bus.inst_ack_i   = 1'b1;
                bus.inst_rdata_i = 32'hDEAD_BEEF;
                wc = 0;
            end else if (rst || !bus.inst_req_o) begin
                wc = 0;
            end else if (wc >= ((bus.inst_addr_o == slow_addr) ? 3 : 0)) begin
                bus.inst_ack_i   = 1'b1;
                bus.inst_rdata_i = mem_data(bus.inst_addr_o);
                wc = 0;
            end else begin
                wc++;
            end
        end
    end

    initial begin
        bus_w.inst_ack_i   = 1'b0;
        bus_w.inst_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            bus_w.inst_ack_i   = bus_w.inst_req_o && !bus_w.inst_ack_i && !rst;
            bus_w.inst_rdata_i = ~bus_w.inst_addr_o;
        end
    end

    // reference model: one outstanding fetch, a stale flag, a pending target, a held entry
    logic        m_busy, m_stale, m_tgt_v, m_held_v, m_ov;
    logic [31:0] m_pc, m_addr, m_tgt, m_held_pc, m_held_inst, m_opc, m_oinst;
    logic        mr_redir, mr_got, mr_issue;
    logic [31:0] mr_tgt;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pc = 32'h0; m_addr = 32'h0; m_tgt = 32'h0;
                m_busy = 1'b0; m_stale = 1'b0; m_tgt_v = 1'b0; m_held_v = 1'b0;
                m_ov = 1'b0; m_opc = 32'h0; m_oinst = 32'h0;
                m_held_pc = 32'h0; m_held_inst = 32'h0;
            end else begin
                mr_redir = flush | branch;
                mr_tgt   = flush ? new_pc : br_tgt;
                mr_issue = !m_busy && !stall[0] && !m_held_v && !mr_redir;
                mr_got   = m_busy && bus.inst_ack_i && !m_stale && !mr_redir;
                if (mr_redir) begin
                    m_ov = 1'b0; m_held_v = 1'b0;
                end else if (mr_got && stall[1]) begin
                    m_held_v = 1'b1; m_held_pc = m_addr; m_held_inst = bus.inst_rdata_i;
                end else if (mr_got) begin
                    m_ov = 1'b1; m_opc = m_addr; m_oinst = bus.inst_rdata_i;
                end else if (!stall[1]) begin
                    m_ov = m_held_v;
                    if (m_held_v) begin m_opc = m_held_pc; m_oinst = m_held_inst; end
                    m_held_v = 1'b0;
                end
                if (m_busy && bus.inst_ack_i) begin
                    m_busy = 1'b0;
                    if (mr_got) m_pc = m_addr + 32'd4;
                end else if (m_busy && mr_redir) begin
                    m_stale = 1'b1;
                end else if (mr_issue) begin
                    m_busy = 1'b1; m_stale = 1'b0;
                    m_addr = m_tgt_v ? m_tgt : m_pc;
                    m_tgt_v = 1'b0;
                end
                if (mr_redir) begin m_tgt = mr_tgt; m_tgt_v = 1'b1; end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("if_valid", {31'b0, if_valid}, {31'b0, m_ov});
                chk("if_pc", if_pc, m_opc);
                chk("if_inst", if_inst, m_oinst);
                chk("inst_req", {31'b0, bus.inst_req_o}, {31'b0, m_busy});
                if (m_busy) chk("inst_addr", bus.inst_addr_o, m_addr);
                chk("stallreq", {31'b0, stallreq}, {31'b0, m_busy && !m_stale && !bus.inst_ack_i});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); #1; rst = 1'b1;
        @(negedge clk); #1; rst = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n;
        n = 0;
        while (!(bus.inst_req_o && bus.inst_addr_o == a) && n < 50) begin
            @(negedge clk); n++;
        end
        chk("wait_req", {31'b0, n < 50}, 32'd1);
    endtask

    task automatic next_req(output logic [31:0] a);
        logic prev;
        int   n;
        prev = bus.inst_req_o;
        a = 'x;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (if_valid && if_inst == 32'h33) seen_33 = 1'b1;
            if (bus.inst_req_o && !prev) begin a = bus.inst_addr_o; break; end
            prev = bus.inst_req_o;
        end
    endtask

    initial begin
        logic [31:0] reqq[$], wq[$], dpc[$], dinst[$];
        logic        prev_req, prev_w;
        logic [31:0] a;
        int          n;
        rst = 1'b1; stall = '0; flush = 1'b0; branch = 1'b0; new_pc = '0; br_tgt = '0;
        slow_addr = 32'hFFFF_FFF0; stray_ack = 1'b0; seen_33 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req", {31'b0, bus.inst_req_o}, 32'd0);
        chk("rst_addr", bus.inst_addr_o, 32'h0);
        chk("rst_addr_w", bus_w.inst_addr_o, 32'hFFFF_FFFC);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
        #1; rst = 1'b0;

        // sequential fetch, and the wrapping instance in parallel
        prev_req = 1'b0; prev_w = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.inst_req_o && !prev_req) reqq.push_back(bus.inst_addr_o);
            if (bus_w.inst_req_o && !prev_w) wq.push_back(bus_w.inst_addr_o);
            if (if_valid) begin dpc.push_back(if_pc); dinst.push_back(if_inst); end
            prev_req = bus.inst_req_o; prev_w = bus_w.inst_req_o;
        end
        chk("s1_addr0", qget(reqq, 0), 32'h0);
        chk("s1_addr1", qget(reqq, 1), 32'h4);
        chk("s1_addr2", qget(reqq, 2), 32'h8);
        chk("s1_inst0", qget(dinst, 0), 32'h11);
        chk("s1_inst1", qget(dinst, 1), 32'h22);
        chk("s1_inst2", qget(dinst, 2), 32'h33);
        chk("s1_pc2", qget(dpc, 2), 32'h8);
        chk("s5_wrap0", qget(wq, 0), 32'hFFFF_FFFC);
        chk("s5_wrap1", qget(wq, 1), 32'h0);

        // branch while the request to 0x8 is outstanding
        do_reset();
        slow_addr = 32'h8;
        wait_req(32'h8);
        branch = 1'b1; br_tgt = 32'h100;
        @(negedge clk);
        branch = 1'b0;
        chk("s2_stallreq_drop", {31'b0, stallreq}, 32'd0);
        seen_33 = 1'b0;
        next_req(a);
        chk("s2_next_addr", a, 32'h100);
        repeat (4) @(negedge clk);
        chk("s2_no_stale", {31'b0, seen_33}, 32'd0);
        slow_addr = 32'hFFFF_FFF0;

        // flush and branch together while the IF output is held
        do_reset();
        n = 0;
        while (!if_valid && n < 20) begin @(negedge clk); n++; end
        chk("s3_first_valid", {31'b0, if_valid}, 32'd1);
        stall = 7'b0000011; flush = 1'b1; new_pc = 32'h0C; branch = 1'b1; br_tgt = 32'h200;
        @(negedge clk);
        flush = 1'b0; branch = 1'b0; stall = '0;
        chk("s3_valid_off", {31'b0, if_valid}, 32'd0);
        next_req(a);
        chk("s3_flush_addr", a, 32'h0C);

        // stall arriving with the ack of 0x10
        do_reset();
        wait_req(32'h10);
        stall = 7'b0000111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s4_hold_inst", if_inst, 32'h5A00_000C);
            chk("s4_no_req", {31'b0, bus.inst_req_o}, 32'd0);
        end
        stall = '0;
        @(negedge clk);
        chk("s4_valid", {31'b0, if_valid}, 32'd1);
        chk("s4_pc", if_pc, 32'h10);
        chk("s4_inst", if_inst, 32'h44);
        @(negedge clk);
        chk("s4_once", {31'b0, if_valid}, 32'd0);
        chk("s4_resume", bus.inst_addr_o, 32'h14);

        // reset while a request is outstanding, then a stray ack
        do_reset();
        slow_addr = 32'h0;
        wait_req(32'h0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_req", {31'b0, bus.inst_req_o}, 32'd0);
        chk("s6_rst_inst", if_inst, 32'h0);
        #1;
        stall = 7'b0000001; rst = 1'b0; stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        chk("s6_stray_valid", {31'b0, if_valid}, 32'd0);
        chk("s6_stray_inst", if_inst, 32'h0);
        slow_addr = 32'hFFFF_FFF0; stall = '0;
        @(negedge clk);
        chk("s6_req", {31'b0, bus.inst_req_o}, 32'd1);
        chk("s6_addr", bus.inst_addr_o, 32'h0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
